// File: rtl/video_out_pkg.sv
// ---------------------------------------------------------------------------
// video_out_pkg
//   Shared definitions for the video output frame loader: FSM state encoding,
//   default frame geometry, burst size, interrupt length and the constant
//   Wishbone byte-select value.
// ---------------------------------------------------------------------------
package video_out_pkg;

    typedef enum logic [2:0] {
        WAIT_ADDR  = 3'd0,
        WAIT_SPACE = 3'd1,
        READ_REQ   = 3'd2,
        WAIT_ACK   = 3'd3,
        FRAME_DONE = 3'd4
    } state_t;

    localparam int          DEF_WIDTH        = 640;
    localparam int          DEF_HEIGHT       = 480;
    localparam int          DEF_NB_PACK_LOAD = 16;

    // Byte offset inside a frame; 20 bits covers 640*480 = 307200 bytes.
    localparam int          OFFSET_W   = 20;
    localparam int          INT_CYCLES = 4;
    localparam logic [3:0]  WB_SEL     = 4'hF;

endpackage : video_out_pkg

// File: rtl/video_out_load.sv
// ---------------------------------------------------------------------------
// video_out_load
//   Wishbone read master that fetches one frame of 8-bit pixels (four per
//   32-bit word) from RAM, starting at a processor-supplied base address, and
//   pushes every word into the FIFO feeding the video generator. The frame is
//   read in bursts of NB_PACK_LOAD single-word classic cycles; a burst only
//   starts once the FIFO reports room for the whole burst. A 4-cycle interrupt
//   marks the end of each frame.
//
//   Optional feature (macro VIDEO_OUT_LOOP_EN): the frame is re-read
//   continuously; a base address written at any time is taken over at the
//   next frame boundary.
//
// Ports
//   clk                   system clock, rising edge
//   nRST                  asynchronous active-low reset
//   wb_reg_ctr            control register, rising edge of bit 0 = new base
//   wb_reg_data           frame base byte address (word aligned)
//   fifo_space_available  FIFO can accept NB_PACK_LOAD words
//   w_req / data_fifo     FIFO write strobe / word
//   interrupt             frame fully read (4-cycle pulse)
//   new_addr              1-cycle pulse on rising edge of wb_reg_ctr[0]
//   p_wb_*                Wishbone master read interface
// ---------------------------------------------------------------------------
module video_out_load
    import video_out_pkg::*;
#(
    parameter int p_WIDTH      = DEF_WIDTH,
    parameter int p_HEIGHT     = DEF_HEIGHT,
    parameter int NB_PACK_LOAD = DEF_NB_PACK_LOAD
) (
    input  logic        clk,
    input  logic        nRST,
    input  logic [31:0] wb_reg_ctr,
    input  logic [31:0] wb_reg_data,
    input  logic        fifo_space_available,
    output logic        w_req,
    output logic [31:0] data_fifo,
    output logic        interrupt,
    output logic        new_addr,
    output logic        p_wb_STB_O,
    output logic        p_wb_CYC_O,
    output logic        p_wb_LOCK_O,
    output logic        p_wb_WE_O,
    output logic [3:0]  p_wb_SEL_O,
    output logic [31:0] p_wb_ADR_O,
    input  logic [31:0] p_wb_DAT_I,
    input  logic        p_wb_ACK_I,
    input  logic        p_wb_ERR_I
);

    localparam logic [OFFSET_W-1:0] FRAME_BYTES = OFFSET_W'(p_WIDTH * p_HEIGHT * 1);
    localparam logic [15:0]         BURST_WORDS = 16'(NB_PACK_LOAD);
    localparam logic [1:0]          INT_LAST    = 2'(INT_CYCLES - 1);

    state_t              state;
    logic [31:0]         base;
    logic [OFFSET_W-1:0] byte_offset;
    logic [OFFSET_W-1:0] next_offset;
    logic [15:0]         word_cnt;
    logic [1:0]          int_cnt;
    logic                q_ctr0;

`ifdef VIDEO_OUT_LOOP_EN
    logic [31:0]         next_base;
    logic                pending;
`endif

    // Only bit 0 of the control register has a meaning for this block.
    logic unused_ctr;
    assign unused_ctr = &{1'b0, wb_reg_ctr[31:1]};

    // Read-only master with a fixed full-word select and no bus locking.
    assign p_wb_LOCK_O = 1'b0;
    assign p_wb_WE_O   = 1'b0;
    assign p_wb_SEL_O  = WB_SEL;

    assign new_addr    = ~q_ctr0 & wb_reg_ctr[0];
    assign next_offset = byte_offset + OFFSET_W'(4);

    // NOTE: all state is updated with non-blocking assignments so every
    // register samples the values from before the edge, independent of
    // statement order inside the block.
    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            q_ctr0 <= 1'b0;
        end else begin
            q_ctr0 <= wb_reg_ctr[0];
        end
    end

    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            state       <= WAIT_ADDR;
            base        <= '0;
            byte_offset <= '0;
            word_cnt    <= '0;
            int_cnt     <= '0;
            p_wb_STB_O  <= 1'b0;
            p_wb_CYC_O  <= 1'b0;
            p_wb_ADR_O  <= '0;
            w_req       <= 1'b0;
            data_fifo   <= '0;
            interrupt   <= 1'b0;
`ifdef VIDEO_OUT_LOOP_EN
            next_base   <= '0;
            pending     <= 1'b0;
`endif
        end else begin
            // NOTE: w_req defaults low every cycle so the ACK branch below
            // produces exactly one write pulse per word.
            w_req <= 1'b0;

            case (state)
                WAIT_ADDR: begin
                    if (new_addr) begin
                        base        <= wb_reg_data;
                        byte_offset <= '0;
                        state       <= WAIT_SPACE;
                    end
                end

                WAIT_SPACE: begin
                    word_cnt <= BURST_WORDS;
                    if (fifo_space_available) begin
                        state <= READ_REQ;
                    end
                end

                READ_REQ: begin
                    p_wb_ADR_O <= base + {{(32-OFFSET_W){1'b0}}, byte_offset};
                    p_wb_STB_O <= 1'b1;
                    p_wb_CYC_O <= 1'b1;
                    state      <= WAIT_ACK;
                end

                WAIT_ACK: begin
                    // ERR wins over a simultaneous ACK: the word is dropped and
                    // the same address is requested again.
                    if (p_wb_ERR_I) begin
                        p_wb_STB_O <= 1'b0;
                        p_wb_CYC_O <= 1'b0;
                        state      <= READ_REQ;
                    end else if (p_wb_ACK_I) begin
                        p_wb_STB_O  <= 1'b0;
                        p_wb_CYC_O  <= 1'b0;
                        data_fifo   <= p_wb_DAT_I;
                        w_req       <= 1'b1;
                        byte_offset <= next_offset;
                        word_cnt    <= word_cnt - 16'd1;
                        if (next_offset == FRAME_BYTES) begin
                            interrupt <= 1'b1;
                            int_cnt   <= '0;
                            state     <= FRAME_DONE;
                        end else if (word_cnt == 16'd1) begin
                            state <= WAIT_SPACE;
                        end else begin
                            state <= READ_REQ;
                        end
                    end
                end

                FRAME_DONE: begin
                    // interrupt was raised on entry; it stays high while
                    // int_cnt walks 0..INT_CYCLES-1.
                    if (int_cnt == INT_LAST) begin
                        interrupt   <= 1'b0;
                        int_cnt     <= '0;
                        byte_offset <= '0;
`ifdef VIDEO_OUT_LOOP_EN
                        if (pending) begin
                            base <= next_base;
                        end
                        pending <= 1'b0;
                        state   <= WAIT_SPACE;
`else
                        state   <= WAIT_ADDR;
`endif
                    end else begin
                        int_cnt <= int_cnt + 2'd1;
                    end
                end

                default: begin
                    state <= WAIT_ADDR;
                end
            endcase

`ifdef VIDEO_OUT_LOOP_EN
            // Placed after the case so a base written in the very cycle a
            // frame ends is kept pending rather than lost.
            if (new_addr && (state != WAIT_ADDR)) begin
                next_base <= wb_reg_data;
                pending   <= 1'b1;
            end
`endif
        end
    end

endmodule : video_out_load

// File: tb/tb_video_out_load.sv
// ---------------------------------------------------------------------------
// tb_video_out_load
//   Directed bench for video_out_load with an 8x2 frame (4 words) and bursts
//   of 2 words. A Wishbone slave model answers each strobe on the following
//   falling edge and logs every requested address; a monitor logs FIFO pushes
//   and counts interrupt cycles. Build with VIDEO_OUT_LOOP_EN to run the
//   continuous-read scenario instead of the single-frame scenarios.
// ---------------------------------------------------------------------------
module tb_video_out_load;

    localparam int W  = 8;
    localparam int H  = 2;
    localparam int NB = 2;

    logic        clk = 1'b0;
    logic        nRST;
    logic [31:0] wb_reg_ctr;
    logic [31:0] wb_reg_data;
    logic        fifo_space_available;
    logic        w_req;
    logic [31:0] data_fifo;
    logic        interrupt;
    logic        new_addr;
    logic        stb, cyc, lock, we;
    logic [3:0]  sel;
    logic [31:0] adr;
    logic [31:0] dat;
    logic        ack, err;

    always #5 clk = ~clk;

    video_out_load #(
        .p_WIDTH      (W),
        .p_HEIGHT     (H),
        .NB_PACK_LOAD (NB)
    ) dut (
        .clk                  (clk),
        .nRST                 (nRST),
        .wb_reg_ctr           (wb_reg_ctr),
        .wb_reg_data          (wb_reg_data),
        .fifo_space_available (fifo_space_available),
        .w_req                (w_req),
        .data_fifo            (data_fifo),
        .interrupt            (interrupt),
        .new_addr             (new_addr),
        .p_wb_STB_O           (stb),
        .p_wb_CYC_O           (cyc),
        .p_wb_LOCK_O          (lock),
        .p_wb_WE_O            (we),
        .p_wb_SEL_O           (sel),
        .p_wb_ADR_O           (adr),
        .p_wb_DAT_I           (dat),
        .p_wb_ACK_I           (ack),
        .p_wb_ERR_I           (err)
    );

    logic [31:0] req_q[$];
    logic [31:0] push_q[$];
    int          int_cycles;
    bit          slave_en;
    bit          err_armed;
    logic [31:0] err_addr;
    int          total;
    int          bad;

    // RAM contents as seen by the slave model.
    function automatic logic [31:0] ram_word(input logic [31:0] a);
        return {a[15:0] ^ 16'h5A5A, a[15:0]};
    endfunction

    // Slave model and monitor, all on the falling edge.
    initial begin
        ack = 1'b0;
        err = 1'b0;
        dat = '0;
        forever begin
            @(negedge clk);
            if (nRST && w_req)     push_q.push_back(data_fifo);
            if (nRST && interrupt) int_cycles++;
            if (ack || err) begin
                ack = 1'b0;
                err = 1'b0;
            end else if (slave_en && stb && cyc) begin
                req_q.push_back(adr);
                if (err_armed && adr == err_addr) begin
                    err       = 1'b1;
                    err_armed = 1'b0;
                end else begin
                    ack = 1'b1;
                    dat = ram_word(adr);
                end
            end
        end
    end

    task automatic clear_logs();
        req_q.delete();
        push_q.delete();
        int_cycles = 0;
    endtask

    task automatic pulse_new_addr(input logic [31:0] base);
        @(negedge clk);
        wb_reg_data = base;
        wb_reg_ctr  = 32'h1;
        #1;
        total++;
        if (new_addr !== 1'b1) begin
            bad++;
            $display("FAIL new_addr_pulse: got %b want 1", new_addr);
        end
        @(negedge clk);
        wb_reg_ctr = 32'h0;
    endtask

    task automatic wait_irq_done(input string name);
        bit saw = 0;
        bit ok  = 0;
        for (int i = 0; i < 400 && !ok; i++) begin
            @(negedge clk);
            if (interrupt) saw = 1;
            else if (saw)  ok  = 1;
        end
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL %s_irq_timeout: frame end got 0 want 1", name);
        end
    endtask

    task automatic wait_reqs(input int n, input string name);
        int i = 0;
        while (req_q.size() < n && i < 400) begin
            @(negedge clk);
            i++;
        end
        total++;
        if (req_q.size() < n) begin
            bad++;
            $display("FAIL %s_req_timeout: requests got %0d want %0d", name, req_q.size(), n);
        end
    endtask

    task automatic test_reset();
        nRST = 1'b0;
        #23;
        total++;
        if ({stb, cyc, lock, we, w_req, interrupt, new_addr} !== 7'b0) begin
            bad++;
            $display("FAIL reset_ctrl: got %b want 0000000",
                     {stb, cyc, lock, we, w_req, interrupt, new_addr});
        end
        total++;
        if (adr !== 32'h0 || data_fifo !== 32'h0) begin
            bad++;
            $display("FAIL reset_data: adr %h fifo %h want 0 0", adr, data_fifo);
        end
        total++;
        if (sel !== 4'hF) begin
            bad++;
            $display("FAIL reset_sel: got %h want f", sel);
        end
        @(negedge clk);
        nRST = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset_mid_ack();
        int i = 0;
        clear_logs();
        slave_en = 0;
        pulse_new_addr(32'h1000);
        while (!stb && i < 20) begin
            @(negedge clk);
            i++;
        end
        total++;
        if (stb !== 1'b1) begin
            bad++;
            $display("FAIL midreset_stb_seen: got %b want 1", stb);
        end
        #2 nRST = 1'b0;
        #1;
        total++;
        if ({stb, cyc, w_req, interrupt} !== 4'b0) begin
            bad++;
            $display("FAIL midreset_release: got %b want 0000", {stb, cyc, w_req, interrupt});
        end
        @(negedge clk);
        nRST     = 1'b1;
        slave_en = 1;
        clear_logs();
        pulse_new_addr(32'h1000);
        wait_irq_done("midreset");
        total++;
        if (req_q.size() < 1 || req_q[0] !== 32'h1000) begin
            bad++;
            $display("FAIL midreset_restart_addr: got %h want 00001000",
                     req_q.size() > 0 ? req_q[0] : 32'hx);
        end
        total++;
        if (push_q.size() != 4) begin
            bad++;
            $display("FAIL midreset_push_count: got %0d want 4", push_q.size());
        end
    endtask

    task automatic test_frame();
        logic [31:0] exp_a[4] = '{32'h1000, 32'h1004, 32'h1008, 32'h100C};
        clear_logs();
        pulse_new_addr(32'h1000);
        wait_irq_done("frame");
        for (int i = 0; i < 4; i++) begin
            total++;
            if (i >= req_q.size() || req_q[i] !== exp_a[i]) begin
                bad++;
                $display("FAIL frame_addr%0d: got %h want %h", i,
                         i < req_q.size() ? req_q[i] : 32'hx, exp_a[i]);
            end
            total++;
            if (i >= push_q.size() || push_q[i] !== ram_word(exp_a[i])) begin
                bad++;
                $display("FAIL frame_data%0d: got %h want %h", i,
                         i < push_q.size() ? push_q[i] : 32'hx, ram_word(exp_a[i]));
            end
        end
        total++;
        if (int_cycles != 4) begin
            bad++;
            $display("FAIL frame_irq_len: got %0d want 4", int_cycles);
        end
        repeat (6) @(negedge clk);
        total++;
        if (stb !== 1'b0 || req_q.size() != 4 || push_q.size() != 4) begin
            bad++;
            $display("FAIL frame_idle: stb %b reqs %0d pushes %0d want 0 4 4",
                     stb, req_q.size(), push_q.size());
        end
    endtask

    task automatic test_fifo_stall();
        int i = 0;
        clear_logs();
        pulse_new_addr(32'h1000);
        while (push_q.size() < 1 && i < 50) begin
            @(negedge clk);
            i++;
        end
        fifo_space_available = 1'b0;
        repeat (12) @(negedge clk);
        total++;
        if (push_q.size() != 2 || req_q.size() != 2 || stb !== 1'b0) begin
            bad++;
            $display("FAIL stall_idle: pushes %0d reqs %0d stb %b want 2 2 0",
                     push_q.size(), req_q.size(), stb);
        end
        fifo_space_available = 1'b1;
        wait_irq_done("stall");
        total++;
        if (req_q.size() < 3 || req_q[2] !== 32'h1008) begin
            bad++;
            $display("FAIL stall_resume_addr: got %h want 00001008",
                     req_q.size() > 2 ? req_q[2] : 32'hx);
        end
        total++;
        if (push_q.size() != 4 || push_q[3] !== ram_word(32'h100C)) begin
            bad++;
            $display("FAIL stall_last_word: count %0d want 4", push_q.size());
        end
    endtask

    task automatic test_err_retry();
        logic [31:0] exp_r[5] = '{32'h1000, 32'h1004, 32'h1004, 32'h1008, 32'h100C};
        logic [31:0] exp_p[4] = '{32'h1000, 32'h1004, 32'h1008, 32'h100C};
        clear_logs();
        err_addr  = 32'h1004;
        err_armed = 1;
        pulse_new_addr(32'h1000);
        wait_irq_done("err");
        total++;
        if (req_q.size() != 5) begin
            bad++;
            $display("FAIL err_req_count: got %0d want 5", req_q.size());
        end
        for (int i = 0; i < 5; i++) begin
            total++;
            if (i >= req_q.size() || req_q[i] !== exp_r[i]) begin
                bad++;
                $display("FAIL err_addr%0d: got %h want %h", i,
                         i < req_q.size() ? req_q[i] : 32'hx, exp_r[i]);
            end
        end
        total++;
        if (push_q.size() != 4) begin
            bad++;
            $display("FAIL err_push_count: got %0d want 4", push_q.size());
        end
        for (int i = 0; i < 4; i++) begin
            total++;
            if (i >= push_q.size() || push_q[i] !== ram_word(exp_p[i])) begin
                bad++;
                $display("FAIL err_data%0d: got %h want %h", i,
                         i < push_q.size() ? push_q[i] : 32'hx, ram_word(exp_p[i]));
            end
        end
    endtask

    task automatic test_addr_ignored();
        int i = 0;
        clear_logs();
        pulse_new_addr(32'h1000);
        while (push_q.size() < 1 && i < 50) begin
            @(negedge clk);
            i++;
        end
        pulse_new_addr(32'h2000);
        wait_irq_done("ignore");
        for (int k = 0; k < 4; k++) begin
            total++;
            if (k >= req_q.size() || req_q[k] !== 32'h1000 + 32'(4 * k)) begin
                bad++;
                $display("FAIL ignore_addr%0d: got %h want %h", k,
                         k < req_q.size() ? req_q[k] : 32'hx, 32'h1000 + 32'(4 * k));
            end
        end
        repeat (10) @(negedge clk);
        total++;
        if (req_q.size() != 4 || stb !== 1'b0) begin
            bad++;
            $display("FAIL ignore_no_restart: reqs %0d stb %b want 4 0", req_q.size(), stb);
        end
        clear_logs();
        pulse_new_addr(32'h2000);
        wait_irq_done("ignore2");
        for (int k = 0; k < 4; k++) begin
            total++;
            if (k >= req_q.size() || req_q[k] !== 32'h2000 + 32'(4 * k)) begin
                bad++;
                $display("FAIL ignore_new_addr%0d: got %h want %h", k,
                         k < req_q.size() ? req_q[k] : 32'hx, 32'h2000 + 32'(4 * k));
            end
        end
    endtask

    task automatic test_loop();
        logic [31:0] exp_l[12] = '{32'h1000, 32'h1004, 32'h1008, 32'h100C,
                                   32'h1000, 32'h1004, 32'h1008, 32'h100C,
                                   32'h2000, 32'h2004, 32'h2008, 32'h200C};
        clear_logs();
        pulse_new_addr(32'h1000);
        wait_reqs(5, "loop_first");
        pulse_new_addr(32'h2000);
        wait_reqs(12, "loop_switch");
        for (int i = 0; i < 12; i++) begin
            total++;
            if (i >= req_q.size() || req_q[i] !== exp_l[i]) begin
                bad++;
                $display("FAIL loop_addr%0d: got %h want %h", i,
                         i < req_q.size() ? req_q[i] : 32'hx, exp_l[i]);
            end
        end
        total++;
        if (int_cycles != 8) begin
            bad++;
            $display("FAIL loop_irq_cycles: got %0d want 8", int_cycles);
        end
    endtask

    initial begin
        total                = 0;
        bad                  = 0;
        wb_reg_ctr           = '0;
        wb_reg_data          = '0;
        fifo_space_available = 1'b1;
        slave_en             = 1;
        err_armed            = 0;
        err_addr             = '0;
        int_cycles           = 0;

        test_reset();
`ifdef VIDEO_OUT_LOOP_EN
        test_loop();
`else
        test_reset_mid_ack();
        test_frame();
        test_fifo_stall();
        test_err_retry();
        test_addr_ignored();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_video_out_load
